usr_sipo_rx: RTL
================

// Module: usr_sipo_rx
// PURPOSE
//  Serial-to-parallel receiver: the far end of the universal shift register link.
//  It collects the bit stream the shift register sends out, one bit per sin_valid.
//  It rebuilds WIDTH-bit words in MSB-first or LSB-first order.
//  Each finished word is offered on a valid/ready output with one holding register,
//  for the downstream parallel consumer.
// PARAMETERS
//  WIDTH   4   word width in bits (>=2)
//  CNT_W   3   bit-counter width; 2**CNT_W > WIDTH
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-low
//  sin        in   1      serial data bit
//  sin_valid  in   1      sin is valid this cycle; one bit accepted per cycle
//  dir        in   1      0: MSB-first (left-shift order); 1: LSB-first (right-shift order)
//  sync       in   1      word framing: discard partial word, restart count
//  out_ready  in   1      consumer accepts out_data this cycle
//  ovr_clr    in   1      clears sticky overrun
//  out_data   out  WIDTH  assembled word (holding register)
//  out_valid  out  1      out_data holds an unconsumed word
//  overrun    out  1      sticky: a completed word was dropped
//  busy       out  1      partial word in progress (state RECV)
// BEHAVIOUR
//  - Reset (rst=0 at posedge): state IDLE, cnt=0, sreg=0, out_data=0,
//    out_valid=0, overrun=0, busy=0. Reset mid-word discards the partial word
//    and any held word.
//  - States: IDLE (cnt=0) and RECV (1<=cnt<=WIDTH-1).
//    - IDLE->RECV on an accepted bit.
//    - RECV->IDLE on the WIDTH-th bit or on sync.
//  - Bit accept (sin_valid=1):
//    - dir is latched on the first bit of a word (cnt=0) and used for the whole word;
//      dir changes mid-word are ignored.
//    - MSB-first: sreg <= {sreg[WIDTH-2:0],sin}.
//    - LSB-first: sreg <= {sin,sreg[WIDTH-1:1]}.
//    - cnt increments. It wraps to 0 on the WIDTH-th bit.
//  - sync=1:
//    - The partial word is discarded and cnt is cleared.
//    - If sin_valid=1 in the same cycle, that bit is bit 0 of a new word:
//      cnt becomes 1, state RECV, and dir is latched.
//  - Completion (WIDTH-th bit accepted):
//    - The full word, including this bit, is the candidate.
//    - If out_valid=0, or out_valid=1 with out_ready=1 in the same cycle:
//      out_data <= candidate and out_valid=1 at the next edge.
//    - Latency: word visible exactly 1 cycle after its last bit is sampled.
//    - If out_valid=1 with out_ready=0: the candidate is dropped, out_data is
//      unchanged, and overrun <= 1.
//  - Output handshake:
//    - out_valid and out_data stay stable until out_valid && out_ready.
//    - A transfer with no completion in the same cycle: out_valid <= 0; out_data holds.
//  - overrun: set only by a dropped word; cleared by ovr_clr=1.
//    If set and clear happen in the same cycle, set wins.
//  - busy = (state==RECV), registered with state.
// TESTING (WIDTH=4)
//  1. dir=0; sin 1,0,1,1 on consecutive cycles -> out_data=4'b1011;
//     out_valid=1 one cycle after the 4th bit.
//  2. dir=1; sin 1,0,1,1 -> out_data=4'b1101; busy=1 after bits 1-3, 0 after bit 4.
//  3. Hold out_ready=0; send word 1011, then word 0110 ->
//     out_data stays 4'b1011, overrun=1; ovr_clr=1 -> overrun=0.
//  4. dir=0; bits 1,1 with idle gaps, sync pulse, then bits 0,0,1,1 ->
//     out_data=4'b0011, only one out_valid.
//  5. Two bits sent, rst=0 for one cycle, then 0,1,0,1 ->
//     all outputs 0 during reset, then out_data=4'b0101.
//  6. out_ready=1 always; 3 back-to-back words 1000,0100,0010 ->
//     each presented once in order; overrun=0.

Source files
------------

// File: rtl/usr_sipo_rx.sv
// Serial-to-parallel receiver: rebuilds WIDTH-bit words from a bit stream (MSB- or LSB-first)
// and offers each finished word through a single valid/ready holding register.
module usr_sipo_rx #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             dir,
    input  logic             sync,
    input  logic             out_ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             overrun,
    output logic             busy
);

    typedef enum logic {IDLE, RECV} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_base, cnt_nxt;
    logic [WIDTH-1:0]   sreg, sreg_base, sreg_nxt;
    logic               dir_q, dir_eff, dir_nxt;
    logic               complete;

    // sync rebases the word so a bit arriving in the same cycle starts a fresh one
    always_comb begin
        cnt_base  = sync ? '0 : cnt;
        sreg_base = sync ? '0 : sreg;
        dir_eff   = (sync || state == IDLE) ? dir : dir_q;
        complete  = sin_valid && (cnt_base == CNT_W'(WIDTH - 1));
        sreg_nxt  = sreg_base;
        cnt_nxt   = cnt_base;
        dir_nxt   = dir_q;
        if (sin_valid) begin
            sreg_nxt = dir_eff ? {sin, sreg_base[WIDTH-1:1]} : {sreg_base[WIDTH-2:0], sin};
            cnt_nxt  = complete ? '0 : cnt_base + CNT_W'(1);
            dir_nxt  = dir_eff;
        end
        state_nxt = (cnt_nxt != '0) ? RECV : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sreg      <= '0;
            dir_q     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RECV);
            cnt   <= cnt_nxt;
            sreg  <= sreg_nxt;
            dir_q <= dir_nxt;

            if (complete && (!out_valid || out_ready)) begin
                out_data  <= sreg_nxt;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // a drop in the same cycle as a clear leaves overrun set
            if (complete && out_valid && !out_ready)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;
        end
    end

endmodule
